// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// State enum, opcodes and datapath mux/ALU select codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_LUI,
        S_TRAP
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle: decode inputs in, control strobes out.
// master = controller, slave = datapath side.
interface mc_controller_if #(parameter int RETW = 32);
    logic [6:0]      op;
    logic            zero;
    logic            mem_ready;
    logic            mem_req;
    logic            AdrSrc;
    logic            IRWrite;
    logic            PCWrite;
    logic            MemWrite;
    logic            RegWrite;
    logic            RegWriteSrc;
    logic [1:0]      ResultSrc;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic [2:0]      ImmSrc;
    logic            illegal;
    logic [RETW-1:0] instret;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, RegWriteSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, RegWriteSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
    );
endinterface

// File: rtl/mc_controller_imm_srcdec.sv
// Immediate-format select decoded straight from the opcode.
// Latency: combinational. Backpressure: none.
module imm_srcdec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] immsrc
);
    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_LW, OP_I: immsrc = IMM_I;
            OP_SW:       immsrc = IMM_S;
            OP_BEQ:      immsrc = IMM_B;
            OP_JAL:      immsrc = IMM_J;
            OP_LUI:      immsrc = IMM_U;
            default:     immsrc = IMM_I;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with retired-instruction counter.
// Latency: lw 5, sw/R/I/jal 4, beq/lui 3 cycles; FETCH/MEMREAD/MEMWRITE hold mem_req until mem_ready.
// Backpressure: memory stalls via mem_ready; reset forces every output low in the same cycle.
module mc_controller
    import riscv_pkg::*;
#(
    parameter int RETW = 32
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    localparam logic [RETW-1:0] RET_ONE = {{(RETW-1){1'b0}}, 1'b1};

    statetype_t      state, state_nxt;
    logic [RETW-1:0] instret_q;
    logic            illegal_q;
    logic            retire;
    logic [2:0]      immsrc;

    logic       mem_req, adrsrc, irwrite, pcupdate, branch, memwrite, regwrite, regwritesrc;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;

    imm_srcdec u_imm_srcdec (.op(bus.op), .immsrc(immsrc));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_LUI:       state_nxt = S_LUI;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_LUI: state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // jal retires through ALUWB, so only terminal states count here.
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    (state == S_LUI) || ((state == S_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire)
                instret_q <= instret_q + RET_ONE;
            if ((state == S_DECODE) && (state_nxt == S_TRAP))
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        adrsrc      = 1'b0;
        irwrite     = 1'b0;
        pcupdate    = 1'b0;
        branch      = 1'b0;
        memwrite    = 1'b0;
        regwrite    = 1'b0;
        regwritesrc = 1'b0;
        resultsrc   = RES_ALUOUT;
        alusrca     = SRCA_PC;
        alusrcb     = SRCB_RS2;
        aluop       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = bus.mem_ready;
                pcupdate  = bus.mem_ready;
            end
            S_DECODE:   begin alusrca = SRCA_OLDPC; alusrcb = SRCB_IMM; end
            S_MEMADR:   begin alusrca = SRCA_RS1;   alusrcb = SRCB_IMM; end
            S_MEMREAD:  begin mem_req = 1'b1; adrsrc = 1'b1; end
            S_MEMWB:    begin resultsrc = RES_DATA; regwrite = 1'b1; end
            S_MEMWRITE: begin mem_req = 1'b1; adrsrc = 1'b1; memwrite = bus.mem_ready; end
            S_EXECR:    begin alusrca = SRCA_RS1; alusrcb = SRCB_RS2; aluop = ALUOP_FUNCT; end
            S_EXECI:    begin alusrca = SRCA_RS1; alusrcb = SRCB_IMM; aluop = ALUOP_FUNCT; end
            S_ALUWB:    regwrite = 1'b1;
            S_BEQ: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            S_LUI:      begin regwrite = 1'b1; regwritesrc = 1'b1; end
            default: ;
        endcase
    end

    assign bus.mem_req     = !reset && mem_req;
    assign bus.AdrSrc      = !reset && adrsrc;
    assign bus.IRWrite     = !reset && irwrite;
    assign bus.PCWrite     = !reset && (pcupdate || (branch && bus.zero));
    assign bus.MemWrite    = !reset && memwrite;
    assign bus.RegWrite    = !reset && regwrite;
    assign bus.RegWriteSrc = !reset && regwritesrc;
    assign bus.ResultSrc   = reset ? 2'b00 : resultsrc;
    assign bus.ALUSrcA     = reset ? 2'b00 : alusrca;
    assign bus.ALUSrcB     = reset ? 2'b00 : alusrcb;
    assign bus.ALUOp       = reset ? 2'b00 : aluop;
    assign bus.ImmSrc      = reset ? 3'b000 : immsrc;
    assign bus.illegal     = !reset && illegal_q;
    assign bus.instret     = reset ? '0 : instret_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control vectors via a scoreboard queue.
module tb_mc_controller;
    localparam int RETW = 4;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111,
                           LUI = 7'b0110111, BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_controller_if #(.RETW(RETW)) bus ();
    mc_controller #(.RETW(RETW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs;

    assign obs = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.MemWrite,
                  bus.RegWrite, bus.RegWriteSrc, bus.ResultSrc, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};

    function automatic logic [18:0] pk(input logic mr, as, irw, pcw, mw, rw, rws,
                                       input logic [1:0] rs, sa, sb, aop,
                                       input logic [2:0] imm, input logic ill);
        return {mr, as, irw, pcw, mw, rw, rws, rs, sa, sb, aop, imm, ill};
    endfunction

    // Expected vectors per state, written from the state table.
    function automatic logic [18:0] e_fetch(input logic rdy, input logic [2:0] imm);
        return pk(1, 0, rdy, rdy, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_decode(input logic [2:0] imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_memadr(input logic [2:0] imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_memrd(input logic [2:0] imm);
        return pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_memwb(input logic [2:0] imm);
        return pk(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_memwr(input logic rdy, input logic [2:0] imm);
        return pk(1, 1, 0, 0, rdy, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_exec(input logic [1:0] sb, input logic [2:0] imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, sb, 2'b10, imm, 0);
    endfunction
    function automatic logic [18:0] e_aluwb(input logic [2:0] imm);
        return pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
    endfunction
    function automatic logic [18:0] e_beq(input logic z);
        return pk(0, 0, 0, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0);
    endfunction
    function automatic logic [18:0] e_jal();
        return pk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0);
    endfunction
    function automatic logic [18:0] e_lui();
        return pk(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 0);
    endfunction
    function automatic logic [18:0] e_trap();
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    endfunction

    // One clock: drive inputs, queue the expected vector, compare at the falling edge.
    task automatic cyc(input logic rst, input logic rdy, input logic z,
                       input logic [18:0] e, input string tag);
        logic [18:0] want;
        reset         = rst;
        bus.mem_ready = rdy;
        bus.zero      = z;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input logic [RETW-1:0] e, input string tag);
        tests++;
        assert (bus.instret === e) else begin
            fails++;
            $error("FAIL %s: instret got %0d expected %0d", tag, bus.instret, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = SW;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 1, 1, '0, "reset_outputs");
        chk_ret(0, "reset_instret");

        // lw, no wait states; mem_ready/zero toggled where they must be ignored
        bus.op = LW;
        cyc(0, 1, 1, e_fetch(1, 3'b000), "lw_fetch");
        cyc(0, 0, 1, e_decode(3'b000), "lw_decode");
        cyc(0, 1, 0, e_memadr(3'b000), "lw_memadr");
        cyc(0, 1, 0, e_memrd(3'b000), "lw_memread");
        chk_ret(0, "lw_instret_before");
        cyc(0, 0, 1, e_memwb(3'b000), "lw_memwb");
        chk_ret(1, "lw_instret_after");

        // sw with three wait cycles in MEMWRITE: 7 cycles total
        bus.op = SW;
        cyc(0, 1, 0, e_fetch(1, 3'b001), "sw_fetch");
        cyc(0, 1, 0, e_decode(3'b001), "sw_decode");
        cyc(0, 0, 0, e_memadr(3'b001), "sw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, e_memwr(0, 3'b001), "sw_memwrite_wait");
        chk_ret(1, "sw_instret_wait");
        cyc(0, 1, 0, e_memwr(1, 3'b001), "sw_memwrite_strobe");
        chk_ret(2, "sw_instret_after");

        // R-type with two fetch wait cycles
        bus.op = RT;
        cyc(0, 0, 0, e_fetch(0, 3'b000), "r_fetch_wait");
        cyc(0, 0, 0, e_fetch(0, 3'b000), "r_fetch_wait");
        cyc(0, 1, 0, e_fetch(1, 3'b000), "r_fetch");
        cyc(0, 1, 0, e_decode(3'b000), "r_decode");
        cyc(0, 1, 0, e_exec(2'b00, 3'b000), "r_execr");
        cyc(0, 1, 0, e_aluwb(3'b000), "r_aluwb");
        chk_ret(3, "r_instret");

        bus.op = IT;
        cyc(0, 1, 0, e_fetch(1, 3'b000), "i_fetch");
        cyc(0, 1, 0, e_decode(3'b000), "i_decode");
        cyc(0, 1, 0, e_exec(2'b01, 3'b000), "i_execi");
        cyc(0, 1, 0, e_aluwb(3'b000), "i_aluwb");
        chk_ret(4, "i_instret");

        bus.op = JAL;
        cyc(0, 1, 0, e_fetch(1, 3'b011), "jal_fetch");
        cyc(0, 1, 0, e_decode(3'b011), "jal_decode");
        cyc(0, 1, 0, e_jal(), "jal_jal");
        chk_ret(4, "jal_instret_mid");
        cyc(0, 1, 0, e_aluwb(3'b011), "jal_aluwb");
        chk_ret(5, "jal_instret");

        bus.op = BEQ;
        cyc(0, 1, 0, e_fetch(1, 3'b010), "beq1_fetch");
        cyc(0, 1, 0, e_decode(3'b010), "beq1_decode");
        cyc(0, 1, 1, e_beq(1), "beq1_taken");
        cyc(0, 1, 0, e_fetch(1, 3'b010), "beq0_fetch");
        cyc(0, 1, 1, e_decode(3'b010), "beq0_decode");
        cyc(0, 1, 0, e_beq(0), "beq0_not_taken");
        chk_ret(7, "beq_instret");

        // lui until the counter is all-ones, then one more wraps it
        bus.op = LUI;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, e_fetch(1, 3'b100), "lui_fetch");
            cyc(0, 1, 1, e_decode(3'b100), "lui_decode");
            cyc(0, 0, 1, e_lui(), "lui_lui");
        end
        chk_ret(15, "instret_all_ones");
        cyc(0, 1, 0, e_fetch(1, 3'b100), "wrap_fetch");
        cyc(0, 1, 0, e_decode(3'b100), "wrap_decode");
        cyc(0, 1, 0, e_lui(), "wrap_lui");
        chk_ret(0, "instret_wrap");
        cyc(0, 1, 0, e_fetch(1, 3'b100), "lui2_fetch");
        cyc(0, 1, 0, e_decode(3'b100), "lui2_decode");
        cyc(0, 1, 0, e_lui(), "lui2_lui");
        chk_ret(1, "lui2_instret");

        // reset during a FETCH wait: outputs and instret low in that very cycle
        bus.op = SW;
        cyc(0, 0, 0, e_fetch(0, 3'b001), "rstf_fetch_wait");
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk_ret(0, "rstf_instret_in_reset");
        @(posedge clk);
        #1;
        cyc(1, 1, 0, '0, "rstf_outputs");
        cyc(0, 0, 0, e_fetch(0, 3'b001), "rstf_fetch_release");
        chk_ret(0, "rstf_instret_after");

        // reset in MEMWRITE with mem_ready high: no store strobe
        cyc(0, 1, 0, e_fetch(1, 3'b001), "rstw_fetch");
        cyc(0, 1, 0, e_decode(3'b001), "rstw_decode");
        cyc(0, 1, 0, e_memadr(3'b001), "rstw_memadr");
        cyc(0, 0, 0, e_memwr(0, 3'b001), "rstw_memwrite");
        cyc(1, 1, 0, '0, "rstw_no_strobe");
        cyc(0, 0, 0, e_fetch(0, 3'b001), "rstw_fetch_release");
        chk_ret(0, "rstw_instret");

        // unknown opcode: trap is absorbing until reset
        bus.op = BAD;
        cyc(0, 1, 0, e_fetch(1, 3'b000), "bad_fetch");
        cyc(0, 1, 0, e_decode(3'b000), "bad_decode");
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 1, e_trap(), "bad_trap");
        chk_ret(0, "bad_instret");
        cyc(1, 1, 0, '0, "bad_reset");
        cyc(0, 1, 0, e_fetch(1, 3'b000), "bad_fetch_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
